// File: rtl/rr_arb_mux.sv
// Purpose: N_IN-way arbitrating mux with packet locking and one registered output stage.
// Latency: 1 cycle from input accept to out_valid; sustains 1 beat/cycle while out_ready=1.
// Backpressure: in_ready follows out_ready combinationally; a stalled output holds all registers.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready - per-channel beat handshake, channel i at [i*WIDTH +: WIDTH]
//   out_data/out_sel/out_last/out_valid/out_ready - registered output beat handshake
//   MODE=0 selects round-robin between packets, MODE=1 fixed priority (channel 0 highest)

module rr_arb_mux #(
   parameter int WIDTH = 32,
   parameter int N_IN  = 4,
   parameter int SEL_W = 2,
   parameter int MODE  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [N_IN-1:0]       in_valid,
   input  logic [N_IN-1:0]       in_last,
   output logic [N_IN-1:0]       in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_sel,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_sel_q, out_sel_d;
   logic             out_last_q, out_last_d;
   logic             out_valid_q, out_valid_d;
   logic             lock_q, lock_d;
   logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

   logic [SEL_W-1:0] grant;
   logic [SEL_W-1:0] idx;
   logic             eligible;
   logic             found;
   logic             space;
   logic             xfer;
   logic [WIDTH-1:0] sel_data;
   logic             sel_last;
   logic             sel_valid;

   // Grant selection. A locked packet owns the output even through its own
   // valid bubbles; otherwise search starts just after the last packet winner.
   always_comb begin
      grant    = '0;
      idx      = '0;
      eligible = 1'b0;
      found    = 1'b0;
      if (lock_q) begin
         grant    = lock_ch_q;
         eligible = 1'b1;
      end else begin
         for (int k = 0; k < N_IN; k++) begin
            if (MODE == 1) begin
               idx = SEL_W'(k);
            end else begin
               // modulo keeps the search inside 0..N_IN-1 for non-power-of-2 N_IN
               idx = SEL_W'((int'(rr_ptr_q) + k + 1) % N_IN);
            end
            if (!found && in_valid[idx]) begin
               grant = idx;
               found = 1'b1;
            end
         end
         eligible = found;
      end
   end

   // Data/last/valid of the granted channel.
   always_comb begin
      sel_data  = '0;
      sel_last  = 1'b0;
      sel_valid = 1'b0;
      for (int i = 0; i < N_IN; i++) begin
         if (grant == SEL_W'(i)) begin
            sel_data  = in_data[i*WIDTH +: WIDTH];
            sel_last  = in_last[i];
            sel_valid = in_valid[i];
         end
      end
   end

   assign space = ~out_valid_q | out_ready;

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N_IN; i++) begin
         in_ready[i] = eligible & (grant == SEL_W'(i)) & space & ~reset;
      end
   end

   assign xfer = eligible & space & ~reset & sel_valid;

   always_comb begin
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      lock_d      = lock_q;
      lock_ch_d   = lock_ch_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer) begin
         out_data_d  = sel_data;
         out_sel_d   = grant;
         out_last_d  = sel_last;
         out_valid_d = 1'b1;
         lock_d      = ~sel_last;
         if (sel_last) begin
            // pointer only advances at packet boundaries
            rr_ptr_d = grant;
         end else begin
            lock_ch_d = grant;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         lock_q      <= 1'b0;
         lock_ch_q   <= '0;
         rr_ptr_q    <= SEL_W'(N_IN - 1);
      end else begin
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
         lock_q      <= lock_d;
         lock_ch_q   <= lock_ch_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_last  = out_last_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Purpose: scoreboard bench for rr_arb_mux in three configurations (RR 4x32, fixed-priority 4x32, RR 3x8).
// Latency: expected beats are queued at accept time and popped by a monitor at output handshake.
// Backpressure: random out_ready stalls, random source bubbles and random reset pulses.

module tb_rr_arb_mux;

   typedef struct packed {
      logic [1:0]  sel;
      logic [31:0] data;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   // per-DUT stimulus: 0 = RR 4x32, 1 = fixed priority 4x32, 2 = RR 3x8
   logic [31:0] dat[3][4];
   logic [3:0]  vld[3];
   logic [3:0]  lst[3];
   logic        ordy[3];

   logic [127:0] a_in_data, b_in_data;
   logic [23:0]  c_in_data;
   logic [3:0]   a_in_valid, b_in_valid, a_in_last, b_in_last;
   logic [2:0]   c_in_valid, c_in_last;
   logic [3:0]   a_rdy, b_rdy;
   logic [2:0]   c_rdy;
   logic [31:0]  a_od, b_od;
   logic [7:0]   c_od;
   logic [1:0]   a_os, b_os, c_os;
   logic         a_ol, b_ol, c_ol, a_ov, b_ov, c_ov;
   logic         a_ordy, b_ordy, c_ordy;

   logic [3:0]   rdy_v[3];
   logic [31:0]  od_v[3];
   logic [1:0]   os_v[3];
   logic         ol_v[3];
   logic         ov_v[3];

   assign a_in_data  = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
   assign b_in_data  = {dat[1][3], dat[1][2], dat[1][1], dat[1][0]};
   assign c_in_data  = {dat[2][2][7:0], dat[2][1][7:0], dat[2][0][7:0]};
   assign a_in_valid = vld[0];
   assign b_in_valid = vld[1];
   assign c_in_valid = vld[2][2:0];
   assign a_in_last  = lst[0];
   assign b_in_last  = lst[1];
   assign c_in_last  = lst[2][2:0];
   assign a_ordy     = ordy[0];
   assign b_ordy     = ordy[1];
   assign c_ordy     = ordy[2];

   assign rdy_v[0] = a_rdy;
   assign rdy_v[1] = b_rdy;
   assign rdy_v[2] = {1'b0, c_rdy};
   assign od_v[0]  = a_od;
   assign od_v[1]  = b_od;
   assign od_v[2]  = {24'h0, c_od};
   assign os_v[0]  = a_os;
   assign os_v[1]  = b_os;
   assign os_v[2]  = c_os;
   assign ol_v[0]  = a_ol;
   assign ol_v[1]  = b_ol;
   assign ol_v[2]  = c_ol;
   assign ov_v[0]  = a_ov;
   assign ov_v[1]  = b_ov;
   assign ov_v[2]  = c_ov;

   rr_arb_mux #(.WIDTH(32), .N_IN(4), .SEL_W(2), .MODE(0)) u_a (
      .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last),
      .in_ready(a_rdy), .out_data(a_od), .out_sel(a_os), .out_last(a_ol), .out_valid(a_ov),
      .out_ready(a_ordy));

   rr_arb_mux #(.WIDTH(32), .N_IN(4), .SEL_W(2), .MODE(1)) u_b (
      .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last),
      .in_ready(b_rdy), .out_data(b_od), .out_sel(b_os), .out_last(b_ol), .out_valid(b_ov),
      .out_ready(b_ordy));

   rr_arb_mux #(.WIDTH(8), .N_IN(3), .SEL_W(2), .MODE(0)) u_c (
      .clk(clk), .reset(reset), .in_data(c_in_data), .in_valid(c_in_valid), .in_last(c_in_last),
      .in_ready(c_rdy), .out_data(c_od), .out_sel(c_os), .out_last(c_ol), .out_valid(c_ov),
      .out_ready(c_ordy));

   initial forever #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   int   phase;
   logic rst_req;

   // reference model state: packet owner (-1 = none), winner of the last
   // finished packet, whether an output beat is held, channel accepted this cycle
   int   owner[3];
   int   last_w[3];
   bit   ovm[3];
   int   acc_ch[3];
   logic [3:0] m1[3];

   exp_t sbq[3][$];

   logic        held[3];
   logic [31:0] snap_d[3];
   logic [1:0]  snap_s[3];
   logic        snap_l[3];
   int          first_sel[3][5];
   int          nlog[3];

   function automatic int n_of(int d);
      return (d == 2) ? 3 : 4;
   endfunction

   function automatic logic [31:0] wmask(int d);
      return (d == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Channel that would be granted: the packet owner if any, else the first
   // valid channel in priority order for that configuration.
   function automatic int pick(int d);
      int n;
      int c;
      n = n_of(d);
      if (owner[d] >= 0) return owner[d];
      for (int k = 0; k < n; k++) begin
         c = (d == 1) ? k : (last_w[d] + 1 + k) % n;
         if (vld[d][c]) return c;
      end
      return -1;
   endfunction

   task automatic model_step(int d);
      int         g;
      bit         sp;
      logic [3:0] er;
      exp_t       e;
      acc_ch[d] = -1;
      if (reset) begin
         owner[d]  = -1;
         last_w[d] = n_of(d) - 1;
         ovm[d]    = 1'b0;
         chk($sformatf("in_ready_in_reset[%0d]", d), rdy_v[d], 0);
         return;
      end
      g  = pick(d);
      sp = !ovm[d] || ordy[d];
      er = '0;
      if (g >= 0 && sp) er[g] = 1'b1;
      chk($sformatf("in_ready[%0d]", d), rdy_v[d], er);
      if (g >= 0 && sp && vld[d][g]) begin
         e.sel  = 2'(g);
         e.data = dat[d][g] & wmask(d);
         e.last = lst[d][g];
         sbq[d].push_back(e);
         acc_ch[d] = g;
         if (lst[d][g]) begin
            owner[d]  = -1;
            last_w[d] = g;
         end else begin
            owner[d] = g;
         end
         ovm[d] = 1'b1;
      end else if (ordy[d]) begin
         ovm[d] = 1'b0;
      end
   endtask

   // Sources keep a beat stable until it is accepted.
   task automatic src_update(int d);
      for (int c = 0; c < n_of(d); c++) begin
         if (phase == 1) begin
            if (m1[d][c]) begin
               if (!vld[d][c] || acc_ch[d] == c) begin
                  vld[d][c] = 1'b1;
                  dat[d][c] = $urandom;
                  lst[d][c] = 1'b1;
               end
            end else begin
               vld[d][c] = 1'b0;
            end
         end else if (phase == 2) begin
            if (!vld[d][c] || acc_ch[d] == c) begin
               if ($urandom_range(0, 3) != 0) begin
                  vld[d][c] = 1'b1;
                  dat[d][c] = $urandom;
                  lst[d][c] = 1'($urandom_range(0, 1));
               end else begin
                  vld[d][c] = 1'b0;
               end
            end
         end else if (phase == 3) begin
            if (acc_ch[d] == c) vld[d][c] = 1'b0;
         end
      end
      ordy[d] = (phase == 2) ? ($urandom_range(0, 3) != 0) : (phase != 0);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      if (reset) begin
         for (int d = 0; d < 3; d++) chk($sformatf("out_valid_after_reset[%0d]", d), ov_v[d], 0);
      end
      if (rst_req && !reset) begin
         for (int d = 0; d < 3; d++) sbq[d].delete();
      end
      reset = rst_req;
      for (int d = 0; d < 3; d++) src_update(d);
      #1;
      for (int d = 0; d < 3; d++) model_step(d);
   endtask

   // Monitor: pops expected beats on each output handshake and checks that a
   // stalled output holds its registers.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            if (held[d]) begin
               chk($sformatf("stall_valid[%0d]", d), ov_v[d], 1);
               chk($sformatf("stall_data[%0d]", d), od_v[d], snap_d[d]);
               chk($sformatf("stall_sel[%0d]", d), os_v[d], snap_s[d]);
               chk($sformatf("stall_last[%0d]", d), ol_v[d], snap_l[d]);
            end
            held[d] = 1'b0;
            if (!reset && ov_v[d]) begin
               if (ordy[d]) begin
                  if (sbq[d].size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL unexpected_beat[%0d] actual=sel %0d data %0h required=no beat", d, os_v[d], od_v[d]);
                  end else begin
                     e = sbq[d].pop_front();
                     chk($sformatf("out_sel[%0d]", d), os_v[d], e.sel);
                     chk($sformatf("out_data[%0d]", d), od_v[d], e.data);
                     chk($sformatf("out_last[%0d]", d), ol_v[d], e.last);
                     if (nlog[d] < 5) begin
                        first_sel[d][nlog[d]] = int'(os_v[d]);
                        nlog[d]++;
                     end
                  end
               end else begin
                  held[d]   = 1'b1;
                  snap_d[d] = od_v[d];
                  snap_s[d] = os_v[d];
                  snap_l[d] = ol_v[d];
               end
            end
         end
      end
   end

   initial begin
      int exp_first[3][5];
      reset   = 1'b1;
      rst_req = 1'b1;
      phase   = 0;
      for (int d = 0; d < 3; d++) begin
         vld[d]    = '0;
         lst[d]    = '0;
         ordy[d]   = 1'b0;
         owner[d]  = -1;
         last_w[d] = n_of(d) - 1;
         ovm[d]    = 1'b0;
         acc_ch[d] = -1;
         held[d]   = 1'b0;
         nlog[d]   = 0;
         for (int c = 0; c < 4; c++) dat[d][c] = '0;
         for (int k = 0; k < 5; k++) first_sel[d][k] = -1;
      end
      m1[0] = 4'b1111;
      m1[1] = 4'b1010;
      m1[2] = 4'b0111;
      exp_first[0] = '{0, 1, 2, 3, 0};
      exp_first[1] = '{1, 1, 1, 1, 1};
      exp_first[2] = '{0, 1, 2, 0, 1};

      repeat (3) cycle();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset_out_valid[%0d]", d), ov_v[d], 0);
         chk($sformatf("reset_out_data[%0d]", d), od_v[d], 0);
         chk($sformatf("reset_out_sel[%0d]", d), os_v[d], 0);
         chk($sformatf("reset_out_last[%0d]", d), ol_v[d], 0);
      end

      // all-valid single-beat packets with a free output
      rst_req = 1'b0;
      phase   = 1;
      repeat (12) cycle();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("first_beats_seen[%0d]", d), nlog[d], 5);
         for (int k = 0; k < 5; k++) begin
            chk($sformatf("first_sel[%0d][%0d]", d, k), first_sel[d][k], exp_first[d][k]);
         end
      end

      // random packets, bubbles, stalls and reset pulses
      phase = 2;
      for (int i = 0; i < 3000; i++) begin
         rst_req = ($urandom_range(0, 79) == 0);
         cycle();
      end

      rst_req = 1'b0;
      phase   = 3;
      repeat (20) cycle();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("beats_left[%0d]", d), sbq[d].size(), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
